// File: rtl/ca_search_pkg.sv
// ca_search_pkg: shared state type, code constants and helpers for the C/A acquisition search sequencer.
// The TRACK state exists only when CA_SEARCH_EARLY_EXIT_EN is defined.
package ca_search_pkg;
    localparam int CA_CODE_LEN = 1023;
    localparam int CA_CHIP_W = 10;
    localparam int CA_PRN_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN,
        S_REPORT
`ifdef CA_SEARCH_EARLY_EXIT_EN
        ,
        S_TRACK
`endif
    } state_t;

    // States in which the generator is out of reset and producing chips
    function automatic logic gen_running(input state_t s);
`ifdef CA_SEARCH_EARLY_EXIT_EN
        return s == S_RUN || s == S_TRACK;
`else
        return s == S_RUN;
`endif
    endfunction
endpackage

// File: rtl/ca_epoch_counter.sv
// ca_epoch_counter: modulo-1023 chip counter with synchronous clear, enable and a wrap indication.
module ca_epoch_counter
    import ca_search_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [CA_CHIP_W-1:0] count,
    output logic                 wrap
);
    localparam logic [CA_CHIP_W-1:0] LAST = CA_CHIP_W'(CA_CODE_LEN - 1);

    assign wrap = en && count == LAST;

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/ca_search_sequencer.sv
// ca_search_sequencer: steps the C/A generator through a PRN range and a ladder of code-phase hypotheses.
// Define CA_SEARCH_EARLY_EXIT_EN to lock onto a hit (TRACK state, found output).
module ca_search_sequencer
    import ca_search_pkg::*;
#(
    parameter int DWELL_PERIODS = 1,
    parameter int PHASE_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CA_PRN_W-1:0]  prn_first,
    input  logic [CA_PRN_W-1:0]  prn_last,
    input  logic                 result_ack,
    input  logic                 result_hit,
    output logic                 gen_reset,
    output logic [CA_PRN_W-1:0]  gen_prn,
    output logic [CA_CHIP_W-1:0] ref_chip,
    output logic [CA_CHIP_W-1:0] gen_chip,
    output logic [CA_CHIP_W-1:0] cur_phase,
    output logic                 dwell_done,
    output logic                 busy,
    output logic                 done,
    output logic                 found
);
    localparam logic [CA_CHIP_W-1:0] LAST = CA_CHIP_W'(CA_CODE_LEN - 1);
    localparam int PW = CA_CHIP_W + 1;

    state_t state, state_n;
    logic [CA_PRN_W-1:0] prn_last_q, gen_prn_n;
    logic [CA_CHIP_W-1:0] cur_phase_n, align_target;
    logic [PW-1:0] phase_sum;
    logic [7:0] periods;
    logic done_n, track_n, dwell_end, gen_wrap, ref_wrap_unused;

    // The generator must start one cycle after ref_chip reaches cur_phase-1
    assign align_target = cur_phase == '0 ? LAST : cur_phase - 1'b1;
    assign phase_sum = {1'b0, cur_phase} + PW'(PHASE_STEP);
    assign dwell_end = gen_chip == LAST && periods == 8'(DWELL_PERIODS - 1);

    ca_epoch_counter u_ref (
        .clk   (clk),
        .reset (reset),
        .clr   (state == S_IDLE || state_n == S_IDLE),
        .en    (state != S_IDLE),
        .count (ref_chip),
        .wrap  (ref_wrap_unused)
    );

    // Cleared while the generator is held, so the first running cycle shows chip 0
    ca_epoch_counter u_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (!gen_running(state) || !gen_running(state_n)),
        .en    (gen_running(state)),
        .count (gen_chip),
        .wrap  (gen_wrap)
    );

`ifdef CA_SEARCH_EARLY_EXIT_EN
    assign track_n = state_n == S_TRACK;
`else
    logic unused_hit;
    assign unused_hit = result_hit;
    assign track_n = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gen_prn_n = gen_prn;
        cur_phase_n = cur_phase;
        done_n = 1'b0;
        if (abort)
            state_n = S_IDLE;
        else case (state)
            S_IDLE: begin
                if (start && prn_first <= prn_last) begin
                    state_n = S_ALIGN;
                    gen_prn_n = prn_first;
                    cur_phase_n = '0;
                end else
                    done_n = start;
            end
            S_ALIGN: state_n = ref_chip == align_target ? S_RUN : S_ALIGN;
            S_RUN: state_n = dwell_end ? S_REPORT : S_RUN;
            S_REPORT: begin
                if (result_ack) begin
`ifdef CA_SEARCH_EARLY_EXIT_EN
                    if (result_hit) begin
                        state_n = S_TRACK;
                        done_n = 1'b1;
                    end else
`endif
                    if (phase_sum <= {1'b0, LAST}) begin
                        cur_phase_n = phase_sum[CA_CHIP_W-1:0];
                        state_n = S_ALIGN;
                    end else if (gen_prn < prn_last_q) begin
                        cur_phase_n = '0;
                        gen_prn_n = gen_prn + 1'b1;
                        state_n = S_ALIGN;
                    end else begin
                        state_n = S_IDLE;
                        done_n = 1'b1;
                    end
                end
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            prn_last_q <= '0;
            periods <= '0;
            gen_reset <= 1'b1;
            gen_prn <= '0;
            cur_phase <= '0;
            dwell_done <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            found <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start && !abort)
                prn_last_q <= prn_last;
            periods <= state != S_RUN ? '0 : gen_wrap ? periods + 1'b1 : periods;
            gen_reset <= !gen_running(state_n);
            gen_prn <= gen_prn_n;
            cur_phase <= cur_phase_n;
            dwell_done <= state_n == S_REPORT;
            busy <= state_n != S_IDLE;
            done <= done_n;
            found <= track_n;
        end
    end
endmodule

// File: tb/tb_ca_search_sequencer.sv
// tb_ca_search_sequencer: directed bench for ca_search_sequencer across three parameter sets.
// Expectations follow CA_SEARCH_EARLY_EXIT_EN when it is defined.
module tb_ca_search_sequencer;
    logic clk, reset;
    logic start [3], abort [3], ack [3], hit [3];
    logic [4:0] pf [3], pl [3];
    logic gen_reset [3], dwell_done [3], busy [3], done [3], found [3];
    logic [4:0] gen_prn [3];
    logic [9:0] ref_chip [3], gen_chip [3], cur_phase [3];
    int n_vec, n_err;

    ca_search_sequencer #(.DWELL_PERIODS(1), .PHASE_STEP(512)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .prn_first(pf[0]), .prn_last(pl[0]), .result_ack(ack[0]), .result_hit(hit[0]),
        .gen_reset(gen_reset[0]), .gen_prn(gen_prn[0]), .ref_chip(ref_chip[0]),
        .gen_chip(gen_chip[0]), .cur_phase(cur_phase[0]), .dwell_done(dwell_done[0]),
        .busy(busy[0]), .done(done[0]), .found(found[0])
    );

    ca_search_sequencer #(.DWELL_PERIODS(1), .PHASE_STEP(1022)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .prn_first(pf[1]), .prn_last(pl[1]), .result_ack(ack[1]), .result_hit(hit[1]),
        .gen_reset(gen_reset[1]), .gen_prn(gen_prn[1]), .ref_chip(ref_chip[1]),
        .gen_chip(gen_chip[1]), .cur_phase(cur_phase[1]), .dwell_done(dwell_done[1]),
        .busy(busy[1]), .done(done[1]), .found(found[1])
    );

    ca_search_sequencer #(.DWELL_PERIODS(3), .PHASE_STEP(700)) dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
        .prn_first(pf[2]), .prn_last(pl[2]), .result_ack(ack[2]), .result_hit(hit[2]),
        .gen_reset(gen_reset[2]), .gen_prn(gen_prn[2]), .ref_chip(ref_chip[2]),
        .gen_chip(gen_chip[2]), .cur_phase(cur_phase[2]), .dwell_done(dwell_done[2]),
        .busy(busy[2]), .done(done[2]), .found(found[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset(input int i);
        check("rst_gen_reset", 32'(gen_reset[i]), 1);
        check("rst_gen_prn", 32'(gen_prn[i]), 0);
        check("rst_ref_chip", 32'(ref_chip[i]), 0);
        check("rst_gen_chip", 32'(gen_chip[i]), 0);
        check("rst_cur_phase", 32'(cur_phase[i]), 0);
        check("rst_dwell_done", 32'(dwell_done[i]), 0);
        check("rst_busy", 32'(busy[i]), 0);
        check("rst_done", 32'(done[i]), 0);
        check("rst_found", 32'(found[i]), 0);
    endtask

    // Entered on the first ALIGN cycle; returns on the first REPORT cycle.
    task automatic run_dwell(input int i, input int prn, input int phase, input int exp_align, input int exp_run);
        int n, bad;
        n = 0;
        while (gen_reset[i] && n < 5000) begin
            n++;
            tick();
        end
        check("align_len", n, exp_align);
        check("run_ref_start", 32'(ref_chip[i]), phase);
        check("run_gen_start", 32'(gen_chip[i]), 0);
        check("run_phase", 32'(cur_phase[i]), phase);
        check("run_prn", 32'(gen_prn[i]), prn);
        n = 0;
        bad = 0;
        while (!dwell_done[i] && n < 20000) begin
            if (int'(gen_chip[i]) != (int'(ref_chip[i]) - phase + 1023) % 1023 || gen_reset[i])
                bad++;
            n++;
            tick();
        end
        check("run_len", n, exp_run);
        check("run_invariant", bad, 0);
        check("report_gen_reset", 32'(gen_reset[i]), 1);
        check("report_phase", 32'(cur_phase[i]), phase);
    endtask

    initial begin
        int n, bad;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; abort[i] = 0; ack[i] = 0; hit[i] = 0; pf[i] = 0; pl[i] = 0;
        end
        tick();
        tick();
        chk_reset(0);
        reset = 1'b0;
        tick();

        // Single PRN, two phases 0 then 512, ack tied high
        pf[0] = 5; pl[0] = 5; ack[0] = 1; start[0] = 1;
        tick();
        start[0] = 0;
        check("start_busy", 32'(busy[0]), 1);
        check("start_ref", 32'(ref_chip[0]), 0);
        check("start_prn", 32'(gen_prn[0]), 5);
        run_dwell(0, 5, 0, 1023, 1023);
        tick();
        check("adv_phase", 32'(cur_phase[0]), 512);
        check("adv_dwell_done", 32'(dwell_done[0]), 0);
        run_dwell(0, 5, 512, 511, 1023);
        tick();
        check("end_done", 32'(done[0]), 1);
        check("end_busy", 32'(busy[0]), 0);
        check("end_prn", 32'(gen_prn[0]), 5);
        tick();
        check("end_done_width", 32'(done[0]), 0);

        // Hit reported on PRN 7 at phase 512
        pf[0] = 7; pl[0] = 7; start[0] = 1;
        tick();
        start[0] = 0;
        run_dwell(0, 7, 0, 1023, 1023);
        tick();
        hit[0] = 1;
        run_dwell(0, 7, 512, 511, 1023);
        tick();
        hit[0] = 0;
        check("hit_done", 32'(done[0]), 1);
        check("hit_phase", 32'(cur_phase[0]), 512);
        check("hit_prn", 32'(gen_prn[0]), 7);
`ifdef CA_SEARCH_EARLY_EXIT_EN
        check("track_found", 32'(found[0]), 1);
        check("track_busy", 32'(busy[0]), 1);
        check("track_gen_reset", 32'(gen_reset[0]), 0);
        check("track_gen_chip0", 32'(gen_chip[0]), 0);
        tick();
        check("track_done_width", 32'(done[0]), 0);
        repeat (1021) tick();
        check("track_gen_last", 32'(gen_chip[0]), 1022);
        tick();
        check("track_gen_wrap", 32'(gen_chip[0]), 0);
        check("track_found_hold", 32'(found[0]), 1);
        abort[0] = 1;
        tick();
        abort[0] = 0;
        check("track_abort_busy", 32'(busy[0]), 0);
        check("track_abort_found", 32'(found[0]), 0);
        check("track_abort_done", 32'(done[0]), 0);
`else
        check("nohit_found", 32'(found[0]), 0);
        check("nohit_busy", 32'(busy[0]), 0);
        check("nohit_gen_reset", 32'(gen_reset[0]), 1);
`endif

        // Two PRNs, phases 0 and 1022 each
        pf[1] = 3; pl[1] = 4; ack[1] = 1; start[1] = 1;
        tick();
        start[1] = 0;
        run_dwell(1, 3, 0, 1023, 1023);
        tick();
        run_dwell(1, 3, 1022, 1021, 1023);
        tick();
        run_dwell(1, 4, 0, 1023, 1023);
        tick();
        run_dwell(1, 4, 1022, 1021, 1023);
        tick();
        check("multi_done", 32'(done[1]), 1);
        check("multi_busy", 32'(busy[1]), 0);

        // Empty PRN range, abort/start collision, then three-period dwell
        pf[2] = 9; pl[2] = 8; start[2] = 1;
        tick();
        start[2] = 0;
        check("empty_done", 32'(done[2]), 1);
        check("empty_busy", 32'(busy[2]), 0);
        tick();
        check("empty_done_width", 32'(done[2]), 0);
        pf[2] = 10; pl[2] = 10; start[2] = 1; abort[2] = 1;
        tick();
        start[2] = 0; abort[2] = 0;
        check("collide_busy", 32'(busy[2]), 0);
        check("collide_done", 32'(done[2]), 0);
        start[2] = 1;
        tick();
        start[2] = 0;
        run_dwell(2, 10, 0, 1023, 3069);
        n = 0;
        bad = 0;
        while (dwell_done[2] && n < 50) begin
            n++;
            if (cur_phase[2] != 0 || !gen_reset[2]) bad++;
            if (n == 10) ack[2] = 1;
            tick();
        end
        ack[2] = 0;
        check("hold_len", n, 10);
        check("hold_state", bad, 0);
        check("hold_adv_phase", 32'(cur_phase[2]), 700);
        n = 0;
        while (gen_reset[2] && n < 5000) begin
            n++;
            tick();
        end
        check("align2_len", n, 690);
        check("align2_ref", 32'(ref_chip[2]), 700);
        n = 0;
        while (gen_chip[2] != 300 && n < 5000) begin
            n++;
            tick();
        end
        check("abort_pos", n, 300);
        abort[2] = 1;
        tick();
        abort[2] = 0;
        check("abort_busy", 32'(busy[2]), 0);
        check("abort_gen_reset", 32'(gen_reset[2]), 1);
        check("abort_dwell_done", 32'(dwell_done[2]), 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (done[2]) bad++;
            tick();
        end
        check("abort_no_done", bad, 0);
        pf[2] = 12; pl[2] = 13; start[2] = 1;
        tick();
        start[2] = 0;
        check("restart_prn", 32'(gen_prn[2]), 12);
        check("restart_phase", 32'(cur_phase[2]), 0);
        check("restart_ref", 32'(ref_chip[2]), 0);
        n = 0;
        while (gen_reset[2] && n < 5000) begin
            n++;
            tick();
        end
        check("restart_align", n, 1023);
        repeat (100) tick();
        check("pre_reset_gen_chip", 32'(gen_chip[2]), 100);
        reset = 1'b1;
        tick();
        chk_reset(2);
        reset = 1'b0;
        tick();
        check("post_reset_busy", 32'(busy[2]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
